// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared state encoding, PC defaults and opcode constants for the fetch unit.
package instr_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    localparam logic [5:0] OP_BEQ    = 6'b100000;
    localparam logic [5:0] OP_BNE    = 6'b101000;
    // Jump opcodes are 0100xx: match on the upper four bits only.
    localparam logic [5:0] OP_J      = 6'b010000;
    localparam logic [5:0] OP_J_MASK = 6'b111100;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// pc_next: combinational next-PC selection (jump over taken branch over sequential).
module pc_next
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] PC_INC = instr_fetch_pkg::PC_INC
) (
    input  logic [31:0] PC,
    input  logic [31:0] Instr,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic        taken;
    logic        unused_instr;

    assign pc4    = PC + PC_INC;
    assign br_off = {{14{Instr[15]}}, Instr[15:0], 2'b00};
    // Instr[29] separates bne (1, taken on !Zero) from beq (0, taken on Zero).
    assign taken  = Branch && (Instr[29] ? !Zero : Zero);

    assign next_pc = Jump  ? {pc4[31:28], Instr[25:0], 2'b00} :
                     taken ? pc4 + br_off : pc4;

    assign unused_instr = ^{Instr[31:30], Instr[28:26]};

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: two-state fetch/issue unit that requests an instruction word,
// holds it for decode until released, then advances the PC.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = instr_fetch_pkg::RESET_PC,
    parameter logic [31:0] PC_INC   = instr_fetch_pkg::PC_INC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [5:0]  opcode,
    output logic [31:0] PC,
    output logic        instr_valid,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        stall
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc;

    pc_next #(.PC_INC(PC_INC)) u_pc_next (
        .PC      (pc_q),
        .Instr   (instr_q),
        .Jump    (Jump),
        .Branch  (Branch),
        .Zero    (Zero),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (state_q == FETCH) begin
            if (imem_ready) begin
                instr_d = imem_rdata;
                valid_d = 1'b1;
                state_d = ISSUE;
            end
        end else if (!stall) begin
            pc_d    = next_pc;
            valid_d = 1'b0;
            state_d = FETCH;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed-vector bench for instr_fetch with hand-computed expectations.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] Instr;
    logic [5:0]  opcode;
    logic [31:0] PC;
    logic        instr_valid;
    logic        Jump = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic        stall = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .opcode      (opcode),
        .PC          (PC),
        .instr_valid (instr_valid),
        .Jump        (Jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Fetch a word (zero-wait), then release it with the given control inputs.
    task automatic run_instr(input logic [31:0] w, input logic j, input logic b, input logic z);
        imem_ready = 1'b1;
        imem_rdata = w;
        tick();
        imem_ready = 1'b0;
        Jump = j;
        Branch = b;
        Zero = z;
        tick();
        Jump = 1'b0;
        Branch = 1'b0;
        Zero = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h1);

        reset = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0020;
        chk("seq_addr0", imem_addr, 32'h0);
        tick();
        chk("seq_valid0", {31'b0, instr_valid}, 32'h1);
        chk("seq_instr0", Instr, 32'h0000_0020);
        chk("seq_req_issue", {31'b0, imem_req}, 32'h0);
        chk("seq_opcode0", {26'b0, opcode}, 32'h0);
        tick();
        chk("seq_addr1", imem_addr, 32'h4);
        chk("seq_valid_off1", {31'b0, instr_valid}, 32'h0);
        chk("seq_req1", {31'b0, imem_req}, 32'h1);
        tick();
        chk("seq_valid1", {31'b0, instr_valid}, 32'h1);
        tick();
        chk("seq_addr2", imem_addr, 32'h8);
        chk("seq_valid_off2", {31'b0, instr_valid}, 32'h0);

        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {31'b0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, 32'h8);
            chk("wait_valid", {31'b0, instr_valid}, 32'h0);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h1000_0040;
        tick();
        chk("wait_done_valid", {31'b0, instr_valid}, 32'h1);
        chk("wait_done_instr", Instr, 32'h1000_0040);
        chk("wait_done_opcode", {26'b0, opcode}, 32'h4);
        imem_ready = 1'b0;
        Jump = 1'b1;
        tick();
        Jump = 1'b0;
        chk("jump_0x100", imem_addr, 32'h100);

        run_instr(32'h8000_0004, 1'b0, 1'b1, 1'b1);
        chk("beq_taken", imem_addr, 32'h114);
        run_instr(32'h1000_0040, 1'b1, 1'b0, 1'b0);
        chk("jump_back1", imem_addr, 32'h100);
        run_instr(32'h8000_0004, 1'b0, 1'b1, 1'b0);
        chk("beq_not_taken", imem_addr, 32'h104);
        run_instr(32'h1000_0040, 1'b1, 1'b0, 1'b0);
        run_instr(32'hA000_FFFF, 1'b0, 1'b1, 1'b0);
        chk("bne_taken_back", imem_addr, 32'h100);
        run_instr(32'hA000_FFFF, 1'b0, 1'b1, 1'b1);
        chk("bne_not_taken", imem_addr, 32'h104);
        run_instr(32'h8000_0004, 1'b0, 1'b0, 1'b1);
        chk("no_branch_seq", imem_addr, 32'h108);

        imem_ready = 1'b1;
        imem_rdata = 32'h4000_0010;
        tick();
        imem_ready = 1'b0;
        stall = 1'b1;
        Jump = 1'b1;
        Branch = 1'b1;
        Zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", PC, 32'h108);
            chk("stall_instr", Instr, 32'h4000_0010);
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
        end
        stall = 1'b0;
        tick();
        Jump = 1'b0;
        Branch = 1'b0;
        Zero = 1'b0;
        chk("jump_over_branch", imem_addr, 32'h40);

        run_instr(32'h8000_FFEE, 1'b0, 1'b1, 1'b1);
        chk("branch_to_top", imem_addr, 32'hFFFF_FFFC);
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        chk("pc_wrap", imem_addr, 32'h0);

        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0020;
        tick();
        imem_ready = 1'b0;
        chk("pre_rst_issue_valid", {31'b0, instr_valid}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_issue_pc", PC, 32'h0);
        chk("rst_issue_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_issue_req", {31'b0, imem_req}, 32'h1);
        chk("rst_issue_instr", Instr, 32'h0);

        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_fetch_pc", PC, 32'h4);
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        reset = 1'b0;
        imem_ready = 1'b0;
        chk("rst_fetch_pc", PC, 32'h0);
        chk("rst_fetch_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_fetch_req", {31'b0, imem_req}, 32'h1);
        chk("rst_fetch_instr", Instr, 32'h0);
        tick();
        chk("rst_discard_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_discard_req", {31'b0, imem_req}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
